// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch sequencer and next-PC controller for the single-cycle
// MIPS core. It runs the imem request/ack handshake for the address held in
// the external PC register. It also resolves stall, branch, jump, exception
// and halt into the value driven on pc_next every cycle.
module pc_sequencer #(
    parameter logic [31:0] EXC_VECTOR = 32'h80000180,
    parameter int          TIMEOUT    = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc_req,
    input  logic        halt,
    output logic [31:0] epc,
    output logic [1:0]  exc_cause,
    output logic        exc_taken,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;
    localparam logic [1:0] CAUSE_EXT     = 2'd2;
    localparam logic [1:0] CAUSE_ALIGN   = 2'd3;

    // The counter holds the number of FETCH cycles that have already gone by
    // without an ack. The timeout therefore fires in the TIMEOUT-th FETCH
    // cycle, i.e. when the count reaches TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic        timeout_hit;
    logic        consume;
    logic [31:0] target;
    logic        exc_fire;
    logic [1:0]  exc_code;

    assign imem_addr   = pc_cur;
    // In the cycle where ack and timeout coincide, the ack wins.
    assign timeout_hit = (state == S_FETCH) && !imem_ack && (wait_cnt == WAIT_LAST);
    assign consume     = (state == S_ISSUE) && !stall;

    // State register; reset abandons any in-flight fetch immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_BOOT;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: if (imem_ack) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (!stall) begin
                    if (!exc_req && halt) state_nxt = S_HALT;
                    else                  state_nxt = S_FETCH;
                end
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_BOOT;
        endcase
    end

    // Output logic: request, next-PC selection and exception detection.
    always_comb begin
        imem_req = 1'b0;
        pc_next  = pc_cur;
        exc_fire = 1'b0;
        exc_code = CAUSE_NONE;
        target   = pc_cur + 32'd4;
        unique case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (timeout_hit) begin
                    pc_next  = EXC_VECTOR;
                    exc_fire = 1'b1;
                    exc_code = CAUSE_TIMEOUT;
                end
            end
            S_ISSUE: begin
                if (consume) begin
                    if (exc_req) begin
                        pc_next  = EXC_VECTOR;
                        exc_fire = 1'b1;
                        exc_code = CAUSE_EXT;
                    end else if (!halt) begin
                        if (jump)              target = jump_target;
                        else if (branch_taken) target = branch_target;
                        if (target[1:0] != 2'b00) begin
                            pc_next  = EXC_VECTOR;
                            exc_fire = 1'b1;
                            exc_code = CAUSE_ALIGN;
                        end else begin
                            pc_next = target;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Fetch wait counter: runs only in FETCH, cleared by ack or timeout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 8'd0;
        end else if (state == S_FETCH) begin
            if (imem_ack || timeout_hit) wait_cnt <= 8'd0;
            else                         wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Instruction capture and state-derived flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (state == S_FETCH && imem_ack) instr <= imem_rdata;
            instr_valid <= (state_nxt == S_ISSUE);
            halted      <= (state_nxt == S_HALT);
        end
    end

    // Exception bookkeeping; epc/cause hold until the next exception.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            epc       <= 32'd0;
            exc_cause <= CAUSE_NONE;
            exc_taken <= 1'b0;
        end else begin
            exc_taken <= exc_fire;
            if (exc_fire) begin
                epc       <= pc_cur;
                exc_cause <= exc_code;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: models the external PC register and drives a
// directed per-cycle vector table, followed by hand-written reset sequences.
module tb_pc_sequencer;

    localparam logic [31:0] XV  = 32'h80000180;
    localparam logic [31:0] RST = 32'h003FFFFC;

    logic        clock;
    logic        reset_n;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc_req;
    logic        halt;
    logic [31:0] epc;
    logic [1:0]  exc_cause;
    logic        exc_taken;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    pc_sequencer #(.EXC_VECTOR(32'h80000180), .TIMEOUT(8)) dut (
        .clock(clock), .reset_n(reset_n), .pc_cur(pc_cur), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .exc_req(exc_req), .halt(halt),
        .epc(epc), .exc_cause(exc_cause), .exc_taken(exc_taken), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the program_counter register (reset by ~reset_n).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pc_cur <= RST;
        else          pc_cur <= pc_next;
    end

    typedef struct {
        logic        ack;
        logic [31:0] rd;
        logic        stl;
        logic        jmp;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        ex;
        logic        hl;
        logic        e_req;
        logic [31:0] e_pc;
        logic [31:0] e_pn;
        logic        e_vld;
        logic [31:0] e_ins;
        logic        e_etk;
        logic [1:0]  e_cause;
        logic [31:0] e_epc;
        logic        e_hlt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ack, input logic [31:0] rd, input logic stl,
                       input logic jmp, input logic [31:0] jt, input logic br,
                       input logic [31:0] bt, input logic ex, input logic hl,
                       input logic e_req, input logic [31:0] e_pc, input logic [31:0] e_pn,
                       input logic e_vld, input logic [31:0] e_ins, input logic e_etk,
                       input logic [1:0] e_cause, input logic [31:0] e_epc, input logic e_hlt);
        vec_t v;
        v.ack = ack; v.rd = rd; v.stl = stl; v.jmp = jmp; v.jt = jt;
        v.br = br; v.bt = bt; v.ex = ex; v.hl = hl;
        v.e_req = e_req; v.e_pc = e_pc; v.e_pn = e_pn; v.e_vld = e_vld;
        v.e_ins = e_ins; v.e_etk = e_etk; v.e_cause = e_cause;
        v.e_epc = e_epc; v.e_hlt = e_hlt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL step %0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input int idx);
        n_vec++;
        chk("rst imem_req",    idx, 32'(imem_req),    32'd0);
        chk("rst instr",       idx, instr,            32'd0);
        chk("rst instr_valid", idx, 32'(instr_valid), 32'd0);
        chk("rst epc",         idx, epc,              32'd0);
        chk("rst exc_cause",   idx, 32'(exc_cause),   32'd0);
        chk("rst exc_taken",   idx, 32'(exc_taken),   32'd0);
        chk("rst halted",      idx, 32'(halted),      32'd0);
        chk("rst pc_next",     idx, pc_next,          RST);
    endtask

    initial begin
        reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
        exc_req = 1'b0; halt = 1'b0;

        // Sequential fetch with same-cycle ack; ack in ISSUE ignored
        add(0,0,0,0,0,0,0,0,0,             0,RST,RST,0,0,0,0,0,0);
        add(1,32'h11111111,0,0,0,0,0,0,0,  1,RST,RST,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,0,0,             0,RST,32'h00400000,1,32'h11111111,0,0,0,0);
        add(1,32'h22222222,0,0,0,0,0,0,0,  1,32'h00400000,32'h00400000,0,32'h11111111,0,0,0,0);
        add(1,32'hDEADBEEF,0,0,0,0,0,0,0,  0,32'h00400000,32'h00400004,1,32'h22222222,0,0,0,0);
        add(1,32'h33333333,0,0,0,0,0,0,0,  1,32'h00400004,32'h00400004,0,32'h22222222,0,0,0,0);
        // Stall 3 cycles with jump pending, then jump
        for (int i = 0; i < 3; i++)
            add(0,0,1,1,32'h00400100,0,0,0,0, 0,32'h00400004,32'h00400004,1,32'h33333333,0,0,0,0);
        add(0,0,0,1,32'h00400100,0,0,0,0,  0,32'h00400004,32'h00400100,1,32'h33333333,0,0,0,0);
        add(1,32'h44444444,0,0,0,0,0,0,0,  1,32'h00400100,32'h00400100,0,32'h33333333,0,0,0,0);
        // exc_req beats jump and branch
        add(0,0,0,1,32'h00400200,1,32'h00400300,1,0, 0,32'h00400100,XV,1,32'h44444444,0,0,0,0);
        // Ack withheld 8 cycles -> timeout on the 8th
        add(0,0,0,0,0,0,0,0,0,             1,XV,XV,0,32'h44444444,1,2,32'h00400100,0);
        for (int i = 0; i < 7; i++)
            add(0,0,0,0,0,0,0,0,0,         1,XV,XV,0,32'h44444444,0,2,32'h00400100,0);
        // Ack on the 8th cycle -> no exception
        add(0,0,0,0,0,0,0,0,0,             1,XV,XV,0,32'h44444444,1,1,XV,0);
        for (int i = 0; i < 6; i++)
            add(0,0,0,0,0,0,0,0,0,         1,XV,XV,0,32'h44444444,0,1,XV,0);
        add(1,32'h55555555,0,0,0,0,0,0,0,  1,XV,XV,0,32'h44444444,0,1,XV,0);
        // Aligned branch, then misaligned branch
        add(0,0,0,0,0,1,32'h00400200,0,0,  0,XV,32'h00400200,1,32'h55555555,0,1,XV,0);
        add(1,32'h66666666,0,0,0,0,0,0,0,  1,32'h00400200,32'h00400200,0,32'h55555555,0,1,XV,0);
        add(0,0,0,0,0,1,32'h00400102,0,0,  0,32'h00400200,XV,1,32'h66666666,0,1,XV,0);
        add(1,32'h77777777,0,0,0,0,0,0,0,  1,XV,XV,0,32'h66666666,1,3,32'h00400200,0);
        // Jump to 0xFFFFFFFC, sequential wrap to 0
        add(0,0,0,1,32'hFFFFFFFC,0,0,0,0,  0,XV,32'hFFFFFFFC,1,32'h77777777,0,3,32'h00400200,0);
        add(1,32'h88888888,0,0,0,0,0,0,0,  1,32'hFFFFFFFC,32'hFFFFFFFC,0,32'h77777777,0,3,32'h00400200,0);
        add(0,0,0,0,0,0,0,0,0,             0,32'hFFFFFFFC,32'h00000000,1,32'h88888888,0,3,32'h00400200,0);
        add(1,32'h99999999,0,0,0,0,0,0,0,  1,32'h00000000,32'h00000000,0,32'h88888888,0,3,32'h00400200,0);
        // Halt beats jump; HALT ignores ack, jump, exc_req
        add(0,0,0,1,32'h00400300,0,0,0,1,  0,32'h00000000,32'h00000000,1,32'h99999999,0,3,32'h00400200,0);
        add(1,32'hAAAAAAAA,0,0,0,0,0,0,0,  0,32'h00000000,32'h00000000,0,32'h99999999,0,3,32'h00400200,1);
        add(1,32'hBBBBBBBB,0,1,32'h00400100,1,32'h00400200,1,0, 0,32'h00000000,32'h00000000,0,32'h99999999,0,3,32'h00400200,1);

        // Reset state
        repeat (2) @(negedge clock);
        #1 check_reset_outputs(-1);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            imem_ack = vecs[i].ack; imem_rdata = vecs[i].rd; stall = vecs[i].stl;
            jump = vecs[i].jmp; jump_target = vecs[i].jt;
            branch_taken = vecs[i].br; branch_target = vecs[i].bt;
            exc_req = vecs[i].ex; halt = vecs[i].hl;
            #1;
            n_vec++;
            chk("imem_req",    i, 32'(imem_req),    32'(vecs[i].e_req));
            chk("imem_addr",   i, imem_addr,        vecs[i].e_pc);
            chk("pc_cur",      i, pc_cur,           vecs[i].e_pc);
            chk("pc_next",     i, pc_next,          vecs[i].e_pn);
            chk("instr_valid", i, 32'(instr_valid), 32'(vecs[i].e_vld));
            chk("instr",       i, instr,            vecs[i].e_ins);
            chk("exc_taken",   i, 32'(exc_taken),   32'(vecs[i].e_etk));
            chk("exc_cause",   i, 32'(exc_cause),   32'(vecs[i].e_cause));
            chk("epc",         i, epc,              vecs[i].e_epc);
            chk("halted",      i, 32'(halted),      32'(vecs[i].e_hlt));
            @(negedge clock);
        end

        // Reset out of HALT clears every registered output
        imem_ack = 1'b0; jump = 1'b0; branch_taken = 1'b0; exc_req = 1'b0; halt = 1'b0;
        #1 reset_n = 1'b0;
        #1 check_reset_outputs(100);
        chk("rst pc model", 100, pc_cur, RST);

        // Release: BOOT has no request, then first fetch at the reset PC
        @(negedge clock);
        reset_n = 1'b1;
        #1 n_vec++;
        chk("boot imem_req", 101, 32'(imem_req), 32'd0);
        @(negedge clock);
        #1 n_vec++;
        chk("fetch imem_req",  102, 32'(imem_req), 32'd1);
        chk("fetch imem_addr", 102, imem_addr,     RST);
        @(negedge clock);
        #1 n_vec++;
        chk("fetch wait req", 103, 32'(imem_req), 32'd1);
        chk("fetch wait pc",  103, pc_next,       RST);

        // Reset mid-FETCH: request drops without a clock edge
        reset_n = 1'b0;
        #1 check_reset_outputs(104);
        @(negedge clock);
        #1 n_vec++;
        chk("held reset req", 105, 32'(imem_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
